cla_arbiter: RTL

//  Shares one registered 32-bit CLA adder (cla_clk) between two requesters.

---
 rtl/cla_arbiter_pkg.sv | 25 ++
 rtl/cla_arbiter_rr_arb2.sv | 42 ++++
 rtl/cla_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cla_arbiter_pkg.sv
// Shared definitions for the two-requester CLA adder arbiter.
// Optional feature macro: SIGNED_OVF_EN (tag also carries operand MSBs).
package cla_arbiter_pkg;

  // Requester identifiers carried in the tag pipe
  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

`ifdef SIGNED_OVF_EN
  localparam int TAG_W = 4;
`else
  localparam int TAG_W = 2;
`endif

  // One tag-pipe entry: valid bit, owner id and (optionally) operand sign bits
  typedef struct packed {
    logic vld;
    logic id;
`ifdef SIGNED_OVF_EN
    logic a_msb;
    logic b_msb;
`endif
  } tag_t;

endpackage

// File: rtl/cla_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. The last_gnt register remembers who won
// the most recent transfer; on a tie the other requester is granted.
// Grants are forced low while reset is asserted.
module rr_arb2
  import cla_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);

  logic last_gnt_reg;

  // Combinational grant: single requester wins outright, ties alternate
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (valid0 && valid1) begin
        gnt0 = (last_gnt_reg == ID_REQ1);
        gnt1 = (last_gnt_reg == ID_REQ0);
      end else begin
        gnt0 = valid0;
        gnt1 = valid1;
      end
    end
  end

  // Remember the winner of each transfer; reset favours requester 0 next
  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt_reg <= ID_REQ1;
    end else if (advance) begin
      last_gnt_reg <= gnt1 ? ID_REQ1 : ID_REQ0;
    end
  end

endmodule

// File: rtl/cla_arbiter.sv
// Shares one registered CLA adder between two requesters. Operands of the
// granted requester are muxed to the adder; a tag pipe of depth ADD_LAT tracks
// which requester owns each result so only the right rspN_valid pulses.
// Optional feature macro: SIGNED_OVF_EN adds rsp0_ovf/rsp1_ovf outputs.
module cla_arbiter
  import cla_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADD_LAT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_ci,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_ci,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_co,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_s,
  output logic             rsp0_co,
`ifdef SIGNED_OVF_EN
  output logic             rsp0_ovf,
  output logic             rsp1_ovf,
`endif
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_s,
  output logic             rsp1_co,
  output logic             busy
);

  logic gnt0;
  logic gnt1;
  logic transfer;
  tag_t tag_in;
  tag_t head;
  tag_t tag_reg [ADD_LAT];
  logic [ADD_LAT-1:0] vld_vec;

  assign transfer   = (req0_valid && gnt0) || (req1_valid && gnt1);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (transfer),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

  // Operand mux toward the adder; zeros when nobody is granted
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (gnt0) begin
      add_a  = req0_a;
      add_b  = req0_b;
      add_ci = req0_ci;
    end else if (gnt1) begin
      add_a  = req1_a;
      add_b  = req1_b;
      add_ci = req1_ci;
    end
  end

  // Tag entering the pipe alongside the operands sampled by the adder
  always_comb begin
    tag_in     = '0;
    tag_in.vld = transfer;
    tag_in.id  = gnt1 ? ID_REQ1 : ID_REQ0;
`ifdef SIGNED_OVF_EN
    tag_in.a_msb = add_a[WIDTH-1];
    tag_in.b_msb = add_b[WIDTH-1];
`endif
  end

  // Tag shift register, aligned so the last stage matches add_s/add_co
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ADD_LAT; i++) tag_reg[i] <= '0;
    end else begin
      tag_reg[0] <= tag_in;
      for (int i = 1; i < ADD_LAT; i++) tag_reg[i] <= tag_reg[i-1];
    end
  end

  for (genvar gi = 0; gi < ADD_LAT; gi++) begin : g_vld
    assign vld_vec[gi] = tag_reg[gi].vld;
  end

  assign busy = |vld_vec;
  assign head = tag_reg[ADD_LAT-1];

  // Sum/carry pass straight through; only the valid strobe is steered
  assign rsp0_valid = head.vld && (head.id == ID_REQ0);
  assign rsp1_valid = head.vld && (head.id == ID_REQ1);
  assign rsp0_s     = add_s;
  assign rsp0_co    = add_co;
  assign rsp1_s     = add_s;
  assign rsp1_co    = add_co;

`ifdef SIGNED_OVF_EN
  logic ovf_raw;
  // Signed overflow: like-signed operands producing a sum of the other sign
  assign ovf_raw  = (head.a_msb == head.b_msb) && (add_s[WIDTH-1] != head.a_msb);
  assign rsp0_ovf = rsp0_valid && ovf_raw;
  assign rsp1_ovf = rsp1_valid && ovf_raw;
`endif

endmodule
